// File: rtl/addr_decoder_if.sv
// Signal bundle between the granted master, the address decoder and its four slave ports.
// A bit moves on a rising clk edge where its valid and the matching ready are both 1; valid and data hold until then.
interface addr_decoder_if;
    logic       bus_busy;
    logic       m_mode;
    logic       m_wr_bus;
    logic       m_master_valid;
    logic       m_master_ready;
    logic       m_slave_ready;
    logic       m_slave_valid;
    logic       m_rd_bus;
    logic [3:0] s_mode;
    logic [3:0] s_wr_bus;
    logic [3:0] s_master_valid;
    logic [3:0] s_master_ready;
    logic [3:0] s_rd_bus;
    logic [3:0] s_slave_ready;
    logic [3:0] s_slave_valid;
    logic [3:0] sel;
    logic       addr_err;

    modport slave (
        input  bus_busy, m_mode, m_wr_bus, m_master_valid, m_master_ready,
        input  s_rd_bus, s_slave_ready, s_slave_valid,
        output m_slave_ready, m_slave_valid, m_rd_bus,
        output s_mode, s_wr_bus, s_master_valid, s_master_ready, sel, addr_err
    );

    modport master (
        output bus_busy, m_mode, m_wr_bus, m_master_valid, m_master_ready,
        output s_rd_bus, s_slave_ready, s_slave_valid,
        input  m_slave_ready, m_slave_valid, m_rd_bus,
        input  s_mode, s_wr_bus, s_master_valid, s_master_ready, sel, addr_err
    );
endinterface

// File: rtl/addr_decoder.sv
// Captures a serial master address, decodes it to one of four slaves, replays the local
// address bits to that slave and then passes the transaction through until the bus is released.
module addr_decoder #(
    parameter int ADDR_WIDTH = 16,
    parameter int S1_AW      = 11,
    parameter int S2_AW      = 12,
    parameter int S3_AW      = 12,
    parameter int BB_AW      = 14
) (
    input  logic          clk,
    input  logic          rstn,
    addr_decoder_if.slave bus,
    output logic [2:0]    fsm_state
);
    typedef enum logic [2:0] {IDLE, ADDR, DECODE, REPLAY, PASS, ERR} state_t;

    localparam int CW = $clog2(ADDR_WIDTH + 1);
    localparam int IW = $clog2(ADDR_WIDTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [CW-1:0]         count;
    logic [IW-1:0]         rep_idx;
    logic [3:0]            sel_q;
    logic                  err_q;
    logic                  rep_bit;

    assign fsm_state    = state;
    assign bus.sel      = sel_q;
    assign bus.addr_err = err_q;
    assign rep_bit      = addr_sr[rep_idx];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            addr_sr <= '0;
            count   <= '0;
            rep_idx <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else if (state != IDLE && !bus.bus_busy) begin
            // Release by the arbiter aborts whatever is in flight, including the last replay bit.
            state   <= IDLE;
            addr_sr <= '0;
            count   <= '0;
            rep_idx <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.bus_busy && bus.m_master_valid) begin
                        addr_sr <= {addr_sr[ADDR_WIDTH-2:0], bus.m_wr_bus};
                        count   <= CW'(1);
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.m_master_valid) begin
                        addr_sr <= {addr_sr[ADDR_WIDTH-2:0], bus.m_wr_bus};
                        count   <= count + CW'(1);
                        if (count == CW'(ADDR_WIDTH - 1)) state <= DECODE;
                    end
                end
                DECODE: begin
                    if (addr_sr[ADDR_WIDTH-1:S1_AW] == '0) begin
                        sel_q   <= 4'b0001;
                        rep_idx <= IW'(S1_AW - 1);
                        state   <= REPLAY;
                    end else if (addr_sr[ADDR_WIDTH-1:S2_AW] == (ADDR_WIDTH - S2_AW)'(1)) begin
                        sel_q   <= 4'b0010;
                        rep_idx <= IW'(S2_AW - 1);
                        state   <= REPLAY;
                    end else if (addr_sr[ADDR_WIDTH-1:S3_AW] == (ADDR_WIDTH - S3_AW)'(2)) begin
                        sel_q   <= 4'b0100;
                        rep_idx <= IW'(S3_AW - 1);
                        state   <= REPLAY;
                    end else if (addr_sr[ADDR_WIDTH-1:BB_AW] == '1) begin
                        sel_q   <= 4'b1000;
                        rep_idx <= IW'(BB_AW - 1);
                        state   <= REPLAY;
                    end else begin
                        sel_q   <= '0;
                        err_q   <= 1'b1;
                        state   <= ERR;
                    end
                end
                REPLAY: begin
                    if (|(sel_q & bus.s_slave_ready)) begin
                        if (rep_idx == '0) state <= PASS;
                        else rep_idx <= rep_idx - IW'(1);
                    end
                end
                PASS, ERR: ;
                default: state <= IDLE;
            endcase
        end
    end

    // Slave-side outputs are masked by sel so unselected ports never see activity.
    always_comb begin
        bus.m_slave_ready  = 1'b0;
        bus.m_slave_valid  = 1'b0;
        bus.m_rd_bus       = 1'b0;
        bus.s_mode         = '0;
        bus.s_wr_bus       = '0;
        bus.s_master_valid = '0;
        bus.s_master_ready = '0;
        case (state)
            IDLE, ADDR: bus.m_slave_ready = 1'b1;
            REPLAY: begin
                bus.s_mode         = sel_q & {4{bus.m_mode}};
                bus.s_wr_bus       = sel_q & {4{rep_bit}};
                bus.s_master_valid = sel_q;
            end
            PASS: begin
                bus.s_mode         = sel_q & {4{bus.m_mode}};
                bus.s_wr_bus       = sel_q & {4{bus.m_wr_bus}};
                bus.s_master_valid = sel_q & {4{bus.m_master_valid}};
                bus.s_master_ready = sel_q & {4{bus.m_master_ready}};
                bus.m_slave_ready  = |(sel_q & bus.s_slave_ready);
                bus.m_slave_valid  = |(sel_q & bus.s_slave_valid);
                bus.m_rd_bus       = |(sel_q & bus.s_rd_bus);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_addr_decoder.sv
// Bench for addr_decoder: bench-side master and slave models, range-based decode reference,
// write/readback data checks, stall, unmapped, abort and reset-in-pass cases plus random transactions.
module tb_addr_decoder;
    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] fsm_state;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic       rx_q [4][$];
    logic       tx_q [4][$];
    logic       rd_got [$];
    logic [7:0] exp_q [$];
    logic [7:0] mem [4];
    bit         m_acc;
    bit         mode_bad;
    bit         err_watch = 1'b0;
    bit         rdy_rand  = 1'b1;
    int         stall_cnt = 0;

    always #5 clk = ~clk;

    addr_decoder_if bus ();

    addr_decoder dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qval(input logic q[$], input int start, input int n);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++)
            v = {v[30:0], (start + k < q.size()) ? q[start + k] : 1'b0};
        return v;
    endfunction

    // Address map as plain ranges.
    function automatic void ref_decode(input logic [15:0] a, output logic [3:0] s, output int w);
        int v;
        v = int'(a);
        s = 4'b0000;
        w = 0;
        if (v < 'h0800) begin s = 4'b0001; w = 11; end
        else if (v >= 'h1000 && v < 'h2000) begin s = 4'b0010; w = 12; end
        else if (v >= 'h2000 && v < 'h3000) begin s = 4'b0100; w = 12; end
        else if (v >= 'hC000) begin s = 4'b1000; w = 14; end
    endfunction

    // One clock: sample handshakes mid-cycle, then drive slave/master-ready inputs after the edge.
    task automatic cyc();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (bus.s_master_valid[i] && bus.s_slave_ready[i]) begin
                rx_q[i].push_back(bus.s_wr_bus[i]);
                if (bus.s_mode[i] !== bus.m_mode) mode_bad = 1'b1;
            end
            if (bus.s_slave_valid[i] && bus.s_master_ready[i] && tx_q[i].size() > 0)
                void'(tx_q[i].pop_front());
        end
        m_acc = bus.m_master_valid && bus.m_slave_ready;
        if (bus.m_slave_valid && bus.m_master_ready) rd_got.push_back(bus.m_rd_bus);
        if (err_watch) begin
            chk("err_no_valid", bus.s_master_valid, 0);
            chk("err_flag", bus.addr_err, 1);
            chk("err_sel", bus.sel, 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            bus.s_slave_ready[i] = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (tx_q[i].size() > 0) begin
                bus.s_slave_valid[i] = 1'($urandom_range(0, 1));
                bus.s_rd_bus[i]      = tx_q[i][0];
            end else begin
                bus.s_slave_valid[i] = 1'b0;
                bus.s_rd_bus[i]      = 1'b0;
            end
        end
        if (stall_cnt > 0) begin
            bus.s_slave_ready[0] = 1'b0;
            stall_cnt--;
        end
        bus.m_master_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic release_bus();
        bus.bus_busy       = 1'b0;
        bus.m_master_valid = 1'b0;
        cyc();
        chk("rel_sel", bus.sel, 0);
        chk("rel_err", bus.addr_err, 0);
        chk("rel_ready", bus.m_slave_ready, 1);
        chk("rel_valid", bus.s_master_valid, 0);
    endtask

    task automatic txn(input logic [15:0] addr, input bit wr, input logic [7:0] data,
                       input bit stall, input bit rst_pass);
        logic [3:0]  es;
        logic [31:0] v;
        logic [7:0]  exp;
        int          w;
        int          idx;
        int          n;
        bit          stalled;
        ref_decode(addr, es, w);
        idx = 0;
        for (int i = 0; i < 4; i++) if (es[i]) idx = i;
        stalled = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_q[i].delete();
            tx_q[i].delete();
        end
        rd_got.delete();
        mode_bad     = 1'b0;
        bus.m_mode   = wr;
        bus.bus_busy = 1'b1;
        for (int b = 15; b >= 0; b--) begin
            bus.m_master_valid = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
            bus.m_master_valid = 1'b1;
            bus.m_wr_bus       = addr[b];
            cyc();
        end
        bus.m_master_valid = 1'b0;
        bus.m_wr_bus       = 1'b0;
        chk("decode_ready", bus.m_slave_ready, 0);
        chk("decode_sel", bus.sel, 0);
        cyc();
        chk("sel", bus.sel, es);
        chk("addr_err", bus.addr_err, (es == 4'b0000));
        chk("first_valid", bus.s_master_valid, es);
        if (es == 4'b0000) begin
            err_watch = 1'b1;
            repeat (4) cyc();
            err_watch = 1'b0;
        end else begin
            n = 0;
            while (rx_q[idx].size() < w && n < 300) begin
                if (stall && !stalled && rx_q[0].size() == 5) begin
                    stalled              = 1'b1;
                    bus.s_slave_ready[0] = 1'b0;
                    stall_cnt            = 2;
                    repeat (3) cyc();
                    chk("stall_hold", rx_q[0].size(), 5);
                    chk("stall_valid", bus.s_master_valid, 4'b0001);
                end
                cyc();
                n++;
            end
            chk("replay_len", rx_q[idx].size(), w);
            chk("local_addr", qval(rx_q[idx], 0, w), 32'(addr) & ((32'd1 << w) - 1));
            if (rst_pass) begin
                bus.m_master_valid = 1'b1;
                bus.m_wr_bus       = 1'b1;
                bus.m_master_ready = 1'b1;
                bus.s_slave_ready  = '0;
                #2 rstn = 1'b0;
                #1;
                chk("rst_m_slave_ready", bus.m_slave_ready, 1);
                chk("rst_sel", bus.sel, 0);
                chk("rst_err", bus.addr_err, 0);
                chk("rst_s_valid", bus.s_master_valid, 0);
                chk("rst_s_mode", bus.s_mode, 0);
                chk("rst_s_wr", bus.s_wr_bus, 0);
                chk("rst_s_mready", bus.s_master_ready, 0);
                bus.m_master_valid = 1'b0;
                bus.m_wr_bus       = 1'b0;
                bus.bus_busy       = 1'b0;
                cyc();
                rstn = 1'b1;
                cyc();
                chk("rst_idle_ready", bus.m_slave_ready, 1);
                return;
            end
            if (wr) begin
                for (int b = 7; b >= 0; b--) begin
                    bus.m_master_valid = 1'b1;
                    bus.m_wr_bus       = data[b];
                    n = 0;
                    do begin
                        cyc();
                        n++;
                    end while (!m_acc && n < 100);
                    chk("wr_accept", m_acc, 1);
                end
                bus.m_master_valid = 1'b0;
                bus.m_wr_bus       = 1'b0;
                chk("wr_len", rx_q[idx].size(), w + 8);
                v = qval(rx_q[idx], w, 8);
                chk("wr_data", v, data);
                mem[idx] = v[7:0];
                exp_q.push_back(data);
            end else begin
                for (int b = 7; b >= 0; b--) tx_q[idx].push_back(mem[idx][b]);
                n = 0;
                while (rd_got.size() < 8 && n < 300) begin
                    cyc();
                    n++;
                end
                chk("rd_len", rd_got.size(), 8);
                if (exp_q.size() > 0) exp = exp_q.pop_front();
                else exp = 'x;
                chk("rd_data", qval(rd_got, 0, 8), exp);
            end
            chk("mode", mode_bad, 0);
        end
        release_bus();
    endtask

    task automatic abort_addr(input logic [15:0] addr, input int nbits);
        bus.m_mode   = 1'b1;
        bus.bus_busy = 1'b1;
        for (int b = 15; b > 15 - nbits; b--) begin
            bus.m_master_valid = 1'b1;
            bus.m_wr_bus       = addr[b];
            cyc();
        end
        release_bus();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: fsm_state=%0d after %0d checks", fsm_state, total);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] rnd;
        logic [7:0]  d;
        int          r;
        bus.bus_busy       = 1'b0;
        bus.m_mode         = 1'b0;
        bus.m_wr_bus       = 1'b0;
        bus.m_master_valid = 1'b0;
        bus.m_master_ready = 1'b0;
        bus.s_rd_bus       = '0;
        bus.s_slave_ready  = '0;
        bus.s_slave_valid  = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", bus.m_slave_ready, 1);
        chk("reset_sel", bus.sel, 0);
        chk("reset_err", bus.addr_err, 0);
        chk("reset_s_valid", bus.s_master_valid, 0);
        chk("reset_m_valid", bus.m_slave_valid, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        txn(16'hC2A5, 1'b1, 8'h5A, 1'b0, 1'b0);
        txn(16'hC2A5, 1'b0, 8'h00, 1'b0, 1'b0);
        txn(16'h1ABC, 1'b1, 8'h3C, 1'b0, 1'b0);
        txn(16'h1ABC, 1'b0, 8'h00, 1'b0, 1'b0);
        txn(16'h2123, 1'b1, 8'h3C, 1'b0, 1'b0);
        txn(16'h2123, 1'b0, 8'h00, 1'b0, 1'b0);
        rdy_rand = 1'b0;
        txn(16'h07FF, 1'b1, 8'h96, 1'b1, 1'b0);
        rdy_rand = 1'b1;
        txn(16'h07FF, 1'b0, 8'h00, 1'b0, 1'b0);
        txn(16'h4000, 1'b1, 8'h11, 1'b0, 1'b0);
        txn(16'h0800, 1'b0, 8'h00, 1'b0, 1'b0);
        abort_addr(16'h1ABC, 7);
        txn(16'h1001, 1'b1, 8'hE1, 1'b0, 1'b0);
        txn(16'h1001, 1'b0, 8'h00, 1'b0, 1'b0);
        txn(16'h2123, 1'b1, 8'h00, 1'b0, 1'b1);
        txn(16'h2123, 1'b1, 8'h77, 1'b0, 1'b0);
        txn(16'h2123, 1'b0, 8'h00, 1'b0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            r   = $urandom_range(0, 4);
            rnd = 16'($urandom);
            case (r)
                0:       a = {5'b00000, rnd[10:0]};
                1:       a = {4'b0001, rnd[11:0]};
                2:       a = {4'b0010, rnd[11:0]};
                3:       a = {2'b11, rnd[13:0]};
                default: a = 16'h3000 + 16'($urandom_range(0, 'h8FFF));
            endcase
            d = 8'($urandom);
            txn(a, 1'b1, d, 1'b0, 1'b0);
            if (r != 4) txn(a, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
